// File: rtl/ram_if_pkg.sv
// Shared widths and FSM state encoding for the RAM responder and its initiator.
// Holds ADDR_W/DATA_W, the ram_state_e encoding and a small max helper.
package ram_if_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RECOVER = 3'd3,
        ST_READ    = 3'd4,
        ST_HOLD    = 3'd5
    } ram_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Initiator-side handshake plus memory-side bus of the RAM responder.
// slave: the responder; master: the initiator and memory model.
interface ram_responder_if;
    import ram_if_pkg::*;

    logic              write_enb;
    logic              read_req;
    logic              read_ack;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              ram_it_hard;
    logic              data_present_bro;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dq_out;
    logic [DATA_W-1:0] mem_dq_in;
    logic              mem_dq_oe;
    logic              mem_ce_n;
    logic              mem_we_n;
    logic              mem_oe_n;

    modport slave (
        input  write_enb, read_req, read_ack,
        input  addr, wr_data, mem_dq_in,
        output rd_data, ram_it_hard, data_present_bro,
        output mem_addr, mem_dq_out, mem_dq_oe,
        output mem_ce_n, mem_we_n, mem_oe_n
    );

    modport master (
        output write_enb, read_req, read_ack,
        output addr, wr_data, mem_dq_in,
        input  rd_data, ram_it_hard, data_present_bro,
        input  mem_addr, mem_dq_out, mem_dq_oe,
        input  mem_ce_n, mem_we_n, mem_oe_n
    );

endinterface

// File: rtl/ram_wait_counter.sv
// Down-counter timing the power-up settle and each memory access.
// Ports: clk, reset, load_i/value_i reload, done_o high on the final cycle.
module ram_wait_counter #(
    parameter int CW        = 5,
    parameter int RESET_VAL = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CW'(RESET_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A value of 1 (or 0 when loaded with 0) marks the last cycle.
    assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/ram_responder.sv
// Single-port async RAM responder: settles after power-up, then serves one
// write or read at a time. Ports: clk, reset, bus (ram_responder_if.slave).
module ram_responder
    import ram_if_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int INIT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    ram_responder_if.slave bus
);

    localparam int CW = $clog2(max_int(WAIT_CYCLES, INIT_CYCLES)) + 1;

    ram_state_e        state_q;
    logic              rdy_q;
    logic              dp_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              dq_oe_q;
    logic              ce_n_q;
    logic              we_n_q;
    logic              oe_n_q;

    logic              cnt_load;
    logic              cnt_done;
    logic [CW-1:0]     cnt_value;

    // Only WRITE and READ are timed by the counter; INIT gets its count
    // from the counter's reset value.
    assign cnt_load  = (state_q == ST_IDLE) &&
                       (bus.write_enb || bus.read_req);
    assign cnt_value = CW'(WAIT_CYCLES);

    ram_wait_counter #(
        .CW        (CW),
        .RESET_VAL (INIT_CYCLES)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .done_o  (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            rdy_q      <= 1'b0;
            dp_q       <= 1'b0;
            rd_data_q  <= '0;
            mem_addr_q <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_done) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Write has priority; a coincident read is dropped.
                    if (bus.write_enb) begin
                        state_q    <= ST_WRITE;
                        mem_addr_q <= bus.addr;
                        dq_out_q   <= bus.wr_data;
                        rdy_q      <= 1'b0;
                        ce_n_q     <= 1'b0;
                        we_n_q     <= 1'b0;
                        dq_oe_q    <= 1'b1;
                    end else if (bus.read_req) begin
                        state_q    <= ST_READ;
                        mem_addr_q <= bus.addr;
                        rdy_q      <= 1'b0;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (cnt_done) begin
                        state_q <= ST_RECOVER;
                        ce_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
                ST_READ: begin
                    if (cnt_done) begin
                        state_q   <= ST_HOLD;
                        rd_data_q <= bus.mem_dq_in;
                        dp_q      <= 1'b1;
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.read_ack) begin
                        state_q <= ST_IDLE;
                        dp_q    <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_it_hard      = rdy_q;
    assign bus.data_present_bro = dp_q;
    assign bus.rd_data          = rd_data_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_dq_out       = dq_out_q;
    assign bus.mem_dq_oe        = dq_oe_q;
    assign bus.mem_ce_n         = ce_n_q;
    assign bus.mem_we_n         = we_n_q;
    assign bus.mem_oe_n         = oe_n_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed and random transactions against a
// word-array reference memory with timing expectations from the access rules.
module tb_ram_responder;
    import ram_if_pkg::*;

    localparam int WAIT = 3;
    localparam int INIT = 16;
    localparam logic [63:0] RST_V =
        {1'b0, 1'b0, 16'h0, 26'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_responder_if bus ();

    ram_responder #(
        .WAIT_CYCLES (WAIT),
        .INIT_CYCLES (INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int oe_cnt = 0;
    logic mem_fill = 1'b1;
    logic [15:0] dev_mem [32];
    logic [15:0] ref_mem [32];

    // Memory device: counts strobe cycles and stores on write strobes.
    always @(posedge clk) begin
        if (!bus.mem_we_n) we_cnt <= we_cnt + 1;
        if (!bus.mem_oe_n) oe_cnt <= oe_cnt + 1;
        if (mem_fill) begin
            for (int i = 0; i < 32; i++) dev_mem[i] <= 16'hA000 + 16'(i);
        end else if (!bus.mem_ce_n && !bus.mem_we_n && bus.mem_dq_oe) begin
            dev_mem[bus.mem_addr[4:0]] <= bus.mem_dq_out;
        end
    end

    always_comb begin
        bus.mem_dq_in = 16'hDEAD;
        if (!bus.mem_ce_n && !bus.mem_oe_n)
            bus.mem_dq_in = dev_mem[bus.mem_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.ram_it_hard, bus.data_present_bro, bus.rd_data,
                bus.mem_addr, bus.mem_dq_out, bus.mem_dq_oe,
                bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.ram_it_hard && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 64'(bus.ram_it_hard), 64'd1);
        chk("idle_strobes",
            64'({bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.mem_dq_oe}),
            64'(4'b1110));
    endtask

    task automatic do_write(input logic [25:0] a, input logic [15:0] d,
                            input bit both);
        int n, w0, o0;
        bit ok;
        wait_ready();
        w0 = we_cnt;
        o0 = oe_cnt;
        bus.write_enb = 1'b1;
        bus.read_req = both;
        bus.addr = a;
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.write_enb = 1'b0;
        bus.read_req = 1'b0;
        bus.addr = 26'($urandom);
        bus.wr_data = 16'($urandom);
        n = 0;
        ok = 1'b1;
        while (!bus.ram_it_hard && n < 50) begin
            bus.read_ack = 1'($urandom);
            if (!bus.mem_we_n && (bus.mem_addr !== a ||
                bus.mem_dq_out !== d || bus.mem_dq_oe !== 1'b1 ||
                bus.mem_ce_n !== 1'b0)) ok = 1'b0;
            if (bus.data_present_bro !== 1'b0) ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        bus.read_ack = 1'b0;
        chk("wr_busy_cycles", 64'(n), 64'(WAIT + 1));
        chk("wr_we_cycles", 64'(we_cnt - w0), 64'(WAIT));
        chk("wr_bus_values", 64'(ok), 64'd1);
        chk("wr_no_oe", 64'(oe_cnt - o0), 64'd0);
        ref_mem[a[4:0]] = d;
    endtask

    task automatic do_read(input logic [25:0] a, input int ack_dly);
        int n, o0;
        bit ok;
        logic [15:0] exp;
        wait_ready();
        o0 = oe_cnt;
        exp = ref_mem[a[4:0]];
        bus.read_req = 1'b1;
        bus.addr = a;
        @(posedge clk); #1;
        bus.read_req = 1'b0;
        bus.addr = 26'($urandom);
        n = 0;
        while (!bus.data_present_bro && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rd_latency", 64'(n), 64'(WAIT));
        chk("rd_data", 64'(bus.rd_data), 64'(exp));
        chk("rd_addr", 64'(bus.mem_addr), 64'(a));
        chk("rd_oe_cycles", 64'(oe_cnt - o0), 64'(WAIT));
        ok = 1'b1;
        repeat (ack_dly) begin
            bus.write_enb = 1'($urandom);
            bus.read_req = 1'($urandom);
            @(posedge clk); #1;
            if (bus.data_present_bro !== 1'b1 || bus.rd_data !== exp ||
                bus.mem_ce_n !== 1'b1 || bus.mem_oe_n !== 1'b1 ||
                bus.mem_we_n !== 1'b1 || bus.ram_it_hard !== 1'b0)
                ok = 1'b0;
        end
        bus.write_enb = 1'b0;
        bus.read_req = 1'b0;
        chk("rd_hold", 64'(ok), 64'd1);
        bus.read_ack = 1'b1;
        @(posedge clk); #1;
        bus.read_ack = 1'b0;
        chk("rd_release",
            64'({bus.data_present_bro, bus.ram_it_hard}), 64'(2'b01));
    endtask

    initial begin
        int n, w0, o0;
        bus.write_enb = 1'b0;
        bus.read_req = 1'b0;
        bus.read_ack = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 16'hA000 + 16'(i);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), RST_V);
        mem_fill = 1'b0;

        // Settle window: requests must be ignored.
        w0 = we_cnt;
        reset = 1'b0;
        bus.write_enb = 1'b1;
        bus.addr = 26'h3;
        n = 0;
        while (!bus.ram_it_hard && n < 100) begin
            @(posedge clk); #1; n++;
        end
        bus.write_enb = 1'b0;
        chk("init_cycles", 64'(n), 64'(INIT));
        chk("init_no_we", 64'(we_cnt - w0), 64'd0);

        do_write(26'h0000010, 16'hBEEF, 1'b0);
        do_read(26'h0000010, 10);
        do_write(26'h0000020, 16'h1234, 1'b1);
        do_read(26'h0000020, 2);
        do_read(26'h0000010, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(26'($urandom), 16'($urandom),
                         ($urandom_range(3, 0) == 0));
            else
                do_read(26'($urandom), int'($urandom_range(5, 0)));
        end

        // Reset in the second READ cycle; the read is abandoned.
        wait_ready();
        bus.read_req = 1'b1;
        bus.addr = 26'h5;
        @(posedge clk); #1;
        bus.read_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("async_reset", outs(), RST_V);
        o0 = oe_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        while (!bus.ram_it_hard && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("reinit_cycles", 64'(n), 64'(INIT));
        chk("reinit_no_dp", 64'(bus.data_present_bro), 64'd0);
        chk("no_retry", 64'(oe_cnt - o0), 64'd0);

        do_write(26'h3FFFFFF, 16'h5A5A, 1'b0);
        do_read(26'h3FFFFFF, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The parameter list SHALL be: WAIT_CYCLES, default 3, memory access cycles per read/write; INIT_CYCLES, default 16, power-up settle cycles before first service.
REQ-002 The port list SHALL be, clock and reset first, one clock; reset is asynchronous and active-high:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- write_enb  in  1  write request from initiator, sampled in IDLE.
- read_req  in  1  read request from initiator, sampled in IDLE.
- read_ack  in  1  initiator has consumed rd_data.
- addr  in  26  word address.
- wr_data  in  16  write word.
- rd_data  out  16  registered read word.
- ram_it_hard  out  1  ready: high only in IDLE.
- data_present_bro  out  1  rd_data valid, held until read_ack.
- mem_addr  out  26  registered memory address.
- mem_dq_out  out  16  memory write data.
- mem_dq_in  in  16  memory read data.
- mem_dq_oe  out  1  data bus drive enable.
- mem_ce_n, mem_we_n, mem_oe_n  out  1 each  active-low strobes.

Function
REQ-003 The FSM SHALL have states INIT, IDLE, WRITE, RECOVER, READ, HOLD; all outputs SHALL be registered.
REQ-004 INIT: a counter SHALL count INIT_CYCLES cycles, then move to IDLE; requests in INIT SHALL be ignored.
REQ-005 IDLE: ram_it_hard=1, all strobes inactive; on a clock edge with write_enb=1, addr/wr_data SHALL be captured into mem_addr/mem_dq_out and the FSM SHALL go to WRITE.
REQ-006 IDLE with read_req=1 and write_enb=0: addr SHALL be captured into mem_addr and the FSM SHALL go to READ.
REQ-007 Simultaneous write_enb and read_req in IDLE: the write SHALL win; the read SHALL be dropped, not queued.
REQ-008 WRITE: mem_ce_n=0, mem_we_n=0, mem_dq_oe=1 for exactly WAIT_CYCLES cycles, then RECOVER.
REQ-009 RECOVER: one cycle with mem_we_n=1, mem_ce_n=1, mem_dq_oe=0, then IDLE; ram_it_hard SHALL be low for exactly WAIT_CYCLES+1 cycles per write.
REQ-010 READ: mem_ce_n=0, mem_oe_n=0, mem_dq_oe=0 for WAIT_CYCLES cycles; on the edge ending the last READ cycle, rd_data SHALL load mem_dq_in and the FSM SHALL go to HOLD.
REQ-011 HOLD: data_present_bro=1, strobes inactive, rd_data stable; on an edge with read_ack=1, data_present_bro SHALL drop and the FSM SHALL return to IDLE.
REQ-012 write_enb/read_req outside IDLE and read_ack outside HOLD SHALL be ignored with no side effect.
REQ-013 The wait counter SHALL be a clog2(max(WAIT_CYCLES,INIT_CYCLES))+1-bit down-counter reloaded on each state entry; WAIT_CYCLES=1 SHALL give a single-cycle access.
REQ-014 addr SHALL pass through unmodified; no range check, no wrap logic in this block.

Reset
REQ-015 Asserting reset at any time, including mid-access, SHALL immediately force INIT, ram_it_hard=0, data_present_bro=0, rd_data=0, mem_addr=0, mem_dq_out=0, mem_dq_oe=0, mem_ce_n=mem_we_n=mem_oe_n=1, counter reloaded to INIT_CYCLES.
REQ-016 An access interrupted by reset SHALL NOT be retried.

Structure
REQ-017 Package ram_if_pkg SHALL hold ADDR_W=26, DATA_W=16 and the state encoding shared with the initiator FSM.
REQ-018 The wait/init counter SHALL be sub-module ram_wait_counter (load, value, done); all else inline.

Verification (WAIT_CYCLES=3, INIT_CYCLES=16)
REQ-019 Release reset -> ram_it_hard rises exactly 16 cycles later; write_enb during that window causes no mem_we_n activity.
REQ-020 Write addr=0x0000010, wr_data=0xBEEF -> mem_we_n low 3 cycles with mem_addr=0x0000010, mem_dq_out=0xBEEF; ram_it_hard low 4 cycles.
REQ-021 Read addr=0x0000010, memory model returns 0xBEEF -> data_present_bro high 3 cycles after request edge, rd_data=0xBEEF, held 10 cycles until read_ack, drops next edge.
REQ-022 write_enb and read_req high same edge (addr=0x20, data=0x1234) -> write only; no mem_oe_n pulse; data_present_bro stays 0.
REQ-023 Reset asserted in 2nd READ cycle -> all outputs at reset values asynchronously; after 16 cycles IDLE with data_present_bro=0.
